// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive FIFO register window.
//   - Register indices of the 4-entry CPU window.
//   - Bit positions inside the status register (read at UART_RXF_STAT).
//   - Bit positions inside the control register (written at UART_RXF_CTRL).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Register window indices
    localparam logic [1:0] UART_RXF_DATA = 2'b00;  // head byte (read pops on strobe)
    localparam logic [1:0] UART_RXF_STAT = 2'b01;  // {5'b0, overflow, full, avail}
    localparam logic [1:0] UART_RXF_CNT  = 2'b10;  // fill count, zero-extended
    localparam logic [1:0] UART_RXF_CTRL = 2'b11;  // write-only control

    // Status register bit positions
    localparam int ST_AVAIL = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

    // Control register bit positions
    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock circular FIFO with 2**DEPTH_LOG2 entries.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_wdata this cycle (accepted if not full, or if a pop
//                 frees a slot in the same cycle)
//   i_wdata     : data to write
//   i_pop       : advance the read pointer (ignored when empty)
//   i_flush     : empty the FIFO; overrides push and pop in the same cycle
//   o_rdata     : entry at the read pointer (undefined content when empty)
//   o_count     : number of stored entries, 0..DEPTH
//   o_full      : count == DEPTH
//   o_empty     : count == 0
// Storage is not reset; only pointers and count are.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [WIDTH-1:0]      o_rdata,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // A pop on a full FIFO frees the slot the same-cycle push lands in,
    // so a full FIFO still accepts a push when it is also being popped.
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset so it maps onto plain RAM/regfile cells.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule : sync_fifo

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer between the UART receiver core and the CPU bus.
// Every rx_data_valid strobe pushes rx_data into a 2**DEPTH_LOG2 entry FIFO;
// the CPU drains it through a 4-register window.
//   clk, rst_n     : clock, asynchronous active-low reset
//   rx_data        : byte from the receiver core
//   rx_data_valid  : single-cycle strobe qualifying rx_data
//   fifo_cs        : register window select
//   R_W_n          : 1 = CPU read, 0 = CPU write
//   reg_addr       : register index (see uart_pkg)
//   data_i         : CPU write data (control register only)
//   data_o         : CPU read data, combinational from reg_addr and state
//   rx_irq         : registered, high while the FIFO is non-empty
// Register map:
//   00 R : head byte (8'h00 when empty); rising edge of the read strobe pops
//   01 R : {5'b0, overflow, full, avail}
//   10 R : count, zero-extended
//   11 W : bit0 flush, bit1 clear overflow; reads return 8'h00
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    input  logic       fifo_cs,
    input  logic       R_W_n,
    input  logic [1:0] reg_addr,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       rx_irq
);

    logic                r_rd_req_d;
    logic                r_overflow;
    logic                r_rx_irq;

    logic                w_rd_req;
    logic                w_pop;
    logic                w_ctrl_wr;
    logic                w_flush;
    logic                w_clr_ovf;
    logic                w_ovf_set;
    logic [7:0]          w_head;
    logic [DEPTH_LOG2:0] w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_avail;
    logic [7:0]          w_status;
    logic                w_unused_data;

    // Bus decode. A read of the data register held over several cycles must
    // pop only once, so the pop is the rising edge of the read strobe.
    assign w_rd_req  = fifo_cs & R_W_n & (reg_addr == UART_RXF_DATA);
    assign w_pop     = w_rd_req & ~r_rd_req_d;
    assign w_ctrl_wr = fifo_cs & ~R_W_n & (reg_addr == UART_RXF_CTRL);
    assign w_flush   = w_ctrl_wr & data_i[CTRL_FLUSH];
    assign w_clr_ovf = w_ctrl_wr & data_i[CTRL_CLR_OVF];

    // Only bits 0 and 1 of the control register exist.
    assign w_unused_data = ^data_i[7:2];

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (rx_data_valid),
        .i_wdata (rx_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_avail = ~w_empty;

    // A byte is lost only when it arrives on a full FIFO with no pop to make
    // room; a flush in the same cycle discards it deliberately, not as an
    // overrun. Full implies non-empty, so any pop strobe here is effective.
    assign w_ovf_set = rx_data_valid & w_full & ~w_pop & ~w_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_req_d <= 1'b0;
            r_overflow <= 1'b0;
            r_rx_irq   <= 1'b0;
        end else begin
            r_rd_req_d <= w_rd_req;
            r_rx_irq   <= w_avail;
            // Set has priority over a same-cycle clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status            = 8'h00;
        w_status[ST_AVAIL]  = w_avail;
        w_status[ST_FULL]   = w_full;
        w_status[ST_OVF]    = r_overflow;
    end

    // The data register shows the pre-pop head during the strobe cycle; the
    // pop itself lands on the following clock edge.
    always_comb begin
        data_o = 8'h00;
        case (reg_addr)
            UART_RXF_DATA: data_o = w_avail ? w_head : 8'h00;
            UART_RXF_STAT: data_o = w_status;
            UART_RXF_CNT:  data_o = 8'(w_count);
            default:       data_o = 8'h00;
        endcase
    end

    assign rx_irq = r_rx_irq;

endmodule : uart_rx_fifo
